// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the EX-stage pipeline (master) and the
// multi-cycle ALU (slave).
interface alu_multicycle_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (output Start, ALUControl, A, B,
                    input  ALUResult, Zero, Busy, Done, Hi, Lo);
    modport slave  (input  Start, ALUControl, A, B,
                    output ALUResult, Zero, Busy, Done, Hi, Lo);
endinterface

// File: rtl/alu_multicycle.sv
// Clocked ALU: single-cycle logic/arith ops plus iterative signed/unsigned
// shift-add multiply and restoring divide into HI/LO.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input logic             Clk,
    input logic             Rst,
    alu_multicycle_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MFHI = 4'b1101;
    localparam logic [3:0] OP_MFLO = 4'b1110;

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p;       // mul: {acc, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   m;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_org;
    logic               is_div, neg_q, neg_r, dz;
    logic [WIDTH-1:0]   result, hi, lo;
    logic               zero, done;

    logic               is_md, sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, sc_res;
    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH-1:0] mul_next, div_next, p_next, fin;
    logic [WIDTH-1:0]   r_n, q_n, r_fix, q_fix;

    assign is_md = (bus.ALUControl[3:2] == 2'b10);
    assign sgn   = ~bus.ALUControl[0];
    assign a_neg = sgn & bus.A[WIDTH-1];
    assign b_neg = sgn & bus.B[WIDTH-1];
    assign a_mag = a_neg ? -bus.A : bus.A;
    assign b_mag = b_neg ? -bus.B : bus.B;

    always_comb begin
        sc_res = '0;
        case (bus.ALUControl)
            OP_AND:  sc_res = bus.A & bus.B;
            OP_OR:   sc_res = bus.A | bus.B;
            OP_XOR:  sc_res = bus.A ^ bus.B;
            OP_NOR:  sc_res = ~(bus.A | bus.B);
            OP_ADD:  sc_res = bus.A + bus.B;
            OP_SUB:  sc_res = bus.A - bus.B;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_SLL:  sc_res = bus.B << bus.A[CW-1:0];
            OP_MFHI: sc_res = hi;
            OP_MFLO: sc_res = lo;
            default: sc_res = '0;
        endcase
    end

    // One shift-add step: conditionally add multiplicand to the upper half, shift right.
    assign sum      = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
    assign mul_next = {sum, p[WIDTH-1:1]};

    // One restoring step: shift {rem,quo} left, keep the subtraction if it did not borrow.
    assign trial    = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, m};
    assign div_next = trial[WIDTH] ? {p[2*WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};

    assign p_next = is_div ? div_next : mul_next;
    assign r_n    = p_next[2*WIDTH-1:WIDTH];
    assign q_n    = p_next[WIDTH-1:0];
    assign r_fix  = neg_r ? -r_n : r_n;
    assign q_fix  = neg_q ? -q_n : q_n;

    always_comb begin
        fin = p_next;
        if (is_div) begin
            if (dz) fin = {a_org, {WIDTH{1'b1}}};
            else    fin = {r_fix, q_fix};
        end else if (neg_q) begin
            fin = -p_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state  <= IDLE;
            cnt    <= '0;
            p      <= '0;
            m      <= '0;
            a_org  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            result <= '0;
            hi     <= '0;
            lo     <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (bus.Start) begin
                    cnt <= '0;
                    if (is_md) begin
                        state  <= RUN;
                        is_div <= bus.ALUControl[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= (bus.B == '0);
                        a_org  <= bus.A;
                        m      <= bus.ALUControl[1] ? b_mag : a_mag;
                        p      <= {{WIDTH{1'b0}}, (bus.ALUControl[1] ? a_mag : b_mag)};
                    end else begin
                        result <= sc_res;
                        zero   <= (sc_res == '0);
                        done   <= 1'b1;
                    end
                end
            end else begin
                p   <= p_next;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(WIDTH-1)) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    hi     <= fin[2*WIDTH-1:WIDTH];
                    lo     <= fin[WIDTH-1:0];
                    result <= fin[WIDTH-1:0];
                    zero   <= (fin[WIDTH-1:0] == '0);
                    done   <= 1'b1;
                end
            end
        end
    end

    assign bus.ALUResult = result;
    assign bus.Zero      = zero;
    assign bus.Busy      = (state == RUN);
    assign bus.Done      = done;
    assign bus.Hi        = hi;
    assign bus.Lo        = lo;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: table-driven single-cycle and mul/div vectors with
// a result scoreboard, plus hand sequences for handshake, reset and WIDTH=8.
module tb_alu_multicycle;
    localparam logic [3:0] AND_ = 4'h0, OR_ = 4'h1, ADD_ = 4'h2, XOR_ = 4'h3;
    localparam logic [3:0] SLL_ = 4'h4, SLTU_ = 4'h5, SUB_ = 4'h6, SLT_ = 4'h7;
    localparam logic [3:0] MULT_ = 4'h8, MULTU_ = 4'h9, DIV_ = 4'hA, DIVU_ = 4'hB;
    localparam logic [3:0] NOR_ = 4'hC, MFHI_ = 4'hD, MFLO_ = 4'hE, UND_ = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(32)) b32();
    alu_multicycle_if #(.WIDTH(8))  b8();

    alu_multicycle #(.WIDTH(32)) u32 (.Clk(clk), .Rst(rst), .bus(b32.slave));
    alu_multicycle #(.WIDTH(8))  u8  (.Clk(clk), .Rst(rst), .bus(b8.slave));

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic        hl;
        logic [31:0] hi, lo;
    } vec_t;

    vec_t sq[$];
    vec_t sc_tab[15];
    vec_t md_tab[7];
    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v);
        b32.Start = 1'b1;
        b32.ALUControl = v.op;
        b32.A = v.a;
        b32.B = v.b;
        sq.push_back(v);
        tick();
    endtask

    task automatic run_md(input vec_t v, input bit noise);
        int cyc, bz;
        cyc = 0;
        bz = 0;
        issue(v);
        b32.Start = 1'b0;
        if (b32.Busy) bz++;
        while (!b32.Done && cyc < 100) begin
            if (noise) begin
                b32.Start = cyc[0];
                b32.ALUControl = ADD_;
                b32.A = $urandom;
                b32.B = $urandom;
            end
            tick();
            cyc++;
            if (b32.Busy) bz++;
        end
        b32.Start = 1'b0;
        chk({v.nm, "_latency"}, 64'(cyc), 64'd32);
        chk({v.nm, "_busycycles"}, 64'(bz), 64'd32);
    endtask

    task automatic run8(input string nm, input logic [3:0] op, input logic [7:0] a, b,
                        input logic [7:0] ehi, elo);
        int cyc;
        cyc = 0;
        b8.Start = 1'b1;
        b8.ALUControl = op;
        b8.A = a;
        b8.B = b;
        tick();
        b8.Start = 1'b0;
        while (!b8.Done && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'd8);
        chk({nm, "_hi"}, 64'(b8.Hi), 64'(ehi));
        chk({nm, "_lo"}, 64'(b8.Lo), 64'(elo));
        chk({nm, "_res"}, 64'(b8.ALUResult), 64'(elo));
    endtask

    // Scoreboard: every Done pops the oldest expectation of the 32-bit instance.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            if (b32.Done && b32.Busy) begin
                ncmp++; nfail++;
                $display("FAIL done_with_busy: Done=1 Busy=1");
            end
            if (b32.Done) begin
                if (sq.size() == 0) begin
                    ncmp++; nfail++;
                    $display("FAIL unexpected_done: got Done=1 expected no result");
                end else begin
                    vec_t e;
                    e = sq.pop_front();
                    chk({e.nm, "_res"}, 64'(b32.ALUResult), 64'(e.res));
                    chk({e.nm, "_zero"}, 64'(b32.Zero), 64'(e.res == 32'd0));
                    if (e.hl) begin
                        chk({e.nm, "_hi"}, 64'(b32.Hi), 64'(e.hi));
                        chk({e.nm, "_lo"}, 64'(b32.Lo), 64'(e.lo));
                    end
                end
            end
        end
    end

    initial begin
        sc_tab[0]  = '{"add",     ADD_,  32'd10, 32'd7, 32'd17, 1'b0, 32'd0, 32'd0};
        sc_tab[1]  = '{"sub",     SUB_,  32'd10, 32'd7, 32'd3,  1'b0, 32'd0, 32'd0};
        sc_tab[2]  = '{"and",     AND_,  32'd1,  32'd3, 32'd1,  1'b0, 32'd0, 32'd0};
        sc_tab[3]  = '{"or",      OR_,   32'd1,  32'd4, 32'd5,  1'b0, 32'd0, 32'd0};
        sc_tab[4]  = '{"slt_gt",  SLT_,  32'd10, 32'd7, 32'd0,  1'b0, 32'd0, 32'd0};
        sc_tab[5]  = '{"slt_lt",  SLT_,  32'd5,  32'd7, 32'd1,  1'b0, 32'd0, 32'd0};
        sc_tab[6]  = '{"sub_eq",  SUB_,  32'd7,  32'd7, 32'd0,  1'b0, 32'd0, 32'd0};
        sc_tab[7]  = '{"slt_neg", SLT_,  32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 32'd0, 32'd0};
        sc_tab[8]  = '{"sltu",    SLTU_, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'd0, 32'd0};
        sc_tab[9]  = '{"sll",     SLL_,  32'd4,  32'd3, 32'h30, 1'b0, 32'd0, 32'd0};
        sc_tab[10] = '{"sll_amt", SLL_,  32'd36, 32'd1, 32'h10, 1'b0, 32'd0, 32'd0};
        sc_tab[11] = '{"undef",   UND_,  32'd5,  32'd6, 32'd0,  1'b0, 32'd0, 32'd0};
        sc_tab[12] = '{"xor",     XOR_,  32'd5,  32'd3, 32'd6,  1'b0, 32'd0, 32'd0};
        sc_tab[13] = '{"nor",     NOR_,  32'd0,  32'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0};
        sc_tab[14] = '{"add_wrap",ADD_,  32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 32'd0, 32'd0};

        md_tab[0] = '{"mult",     MULT_,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
        md_tab[1] = '{"mult_min", MULT_,  32'h80000000, 32'h80000000, 32'd0, 1'b1, 32'h40000000, 32'd0};
        md_tab[2] = '{"div_neg",  DIV_,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
        md_tab[3] = '{"div_negb", DIV_,   32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 32'd1, 32'hFFFFFFFD};
        md_tab[4] = '{"div_zero", DIV_,   32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 32'd5, 32'hFFFFFFFF};
        md_tab[5] = '{"div_ovf",  DIV_,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32'd0, 32'h80000000};
        md_tab[6] = '{"divu",     DIVU_,  32'd100, 32'd7, 32'd14, 1'b1, 32'd2, 32'd14};

        b32.Start = 1'b0; b32.ALUControl = '0; b32.A = '0; b32.B = '0;
        b8.Start = 1'b0;  b8.ALUControl = '0;  b8.A = '0;  b8.B = '0;
        rst = 1'b0;
        tick(); tick();
        chk("rst_res",  64'(b32.ALUResult), 64'd0);
        chk("rst_zero", 64'(b32.Zero), 64'd1);
        chk("rst_busy", 64'(b32.Busy), 64'd0);
        chk("rst_done", 64'(b32.Done), 64'd0);
        chk("rst_hilo", {b32.Hi, b32.Lo}, 64'd0);
        rst = 1'b1;
        tick();

        // Back-to-back single-cycle ops: Done every cycle.
        for (int i = 0; i < 15; i++) begin
            issue(sc_tab[i]);
            chk({sc_tab[i].nm, "_done"}, 64'(b32.Done), 64'd1);
        end
        b32.Start = 1'b0;
        tick();
        chk("done_clear", 64'(b32.Done), 64'd0);
        chk("hilo_untouched", {b32.Hi, b32.Lo}, 64'd0);

        for (int i = 0; i < 7; i++) run_md(md_tab[i], (i == 2));

        // MULTU then MFHI accepted in the Done cycle, MFLO right after.
        begin
            vec_t v;
            v = '{"multu", MULTU_, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFE};
            run_md(v, 1'b0);
            v = '{"mfhi", MFHI_, 32'd0, 32'd0, 32'd1, 1'b1, 32'd1, 32'hFFFFFFFE};
            issue(v);
            chk("mfhi_done", 64'(b32.Done), 64'd1);
            v = '{"mflo", MFLO_, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFE};
            issue(v);
            b32.Start = 1'b0;
            tick();
        end

        // Reset at iteration 10 of a MULT aborts it; reset also beats Start.
        b32.Start = 1'b1; b32.ALUControl = MULT_; b32.A = 32'hFFFFFFFD; b32.B = 32'd7;
        tick();
        b32.Start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_busy", 64'(b32.Busy), 64'd1);
        rst = 1'b0;
        b32.Start = 1'b1; b32.ALUControl = ADD_; b32.A = 32'd1; b32.B = 32'd1;
        tick();
        chk("abort_res",  64'(b32.ALUResult), 64'd0);
        chk("abort_zero", 64'(b32.Zero), 64'd1);
        chk("abort_busy", 64'(b32.Busy), 64'd0);
        chk("abort_done", 64'(b32.Done), 64'd0);
        b32.Start = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 35; i++) tick();
        chk("abort_hilo", {b32.Hi, b32.Lo}, 64'd0);
        chk("abort_idle", 64'(b32.Busy), 64'd0);
        begin
            vec_t v;
            v = '{"divu_after", DIVU_, 32'd100, 32'd7, 32'd14, 1'b1, 32'd2, 32'd14};
            run_md(v, 1'b0);
        end
        tick();

        run8("w8_multu", MULTU_, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        run8("w8_div",   DIV_,   8'h80, 8'hFF, 8'h00, 8'h80);
        tick(); tick();
        chk("scoreboard_empty", 64'(sq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
